// File: rtl/sprite_compositor.sv
// Multi-sprite VGA pixel engine: fetches sprite and background pixels from one image SRAM,
// chroma-keys the highest-priority sprite over the background and animates sprite motion per frame.
module sprite_compositor #(
    parameter int          NUM_SPR    = 3,
    parameter int          ADDR_W     = 18,
    parameter int          VBUF_W     = 320,
    parameter int          VBUF_H     = 240,
    parameter int          SCALE_SH   = 1,
    parameter int          SPR_W      = 64,
    parameter int          SPR_H      = 32,
    parameter int          SPR_FRAMES = 2,
    parameter int          SPR_Y0     = 64,
    parameter int          SPR_DY     = 48,
    parameter logic [11:0] KEY_COLOR  = 12'h0F0,
    parameter int          ANIM_DIV   = 8,
    parameter int          BOUNCE     = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pixel_tick,
    input  logic               video_on,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic               frame_tick,
    input  logic               pause,
    input  logic [NUM_SPR-1:0] spr_en,
    output logic [ADDR_W-1:0]  sram_addr,
    input  logic [11:0]        sram_data,
    output logic [11:0]        rgb,
    output logic               overrun
);
    // Address arithmetic runs at full address width so no partial sum is truncated.
    localparam int CW     = (ADDR_W > 12) ? ADDR_W : 12;
    localparam int POS_W  = $clog2(VBUF_W + SPR_W + NUM_SPR + 1);
    localparam int ANIM_W = (SPR_FRAMES > 1) ? $clog2(SPR_FRAMES) : 1;
    localparam int DIV_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [CW-1:0] VBUF_W_C  = CW'(VBUF_W);
    localparam logic [CW-1:0] SPR_W_C   = CW'(SPR_W);
    localparam logic [CW-1:0] SPR_H_C   = CW'(SPR_H);
    localparam logic [CW-1:0] BG_SIZE_C = CW'(VBUF_W * VBUF_H);
    localparam logic [CW-1:0] MAX_POS_C = CW'(VBUF_W + SPR_W);
    localparam logic [CW-1:0] ONE_C     = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPR,
        ST_BG,
        ST_CAP1,
        ST_CAP2
    } state_t;

    state_t state_reg, state_next;

    logic              latch_en, issue_spr, issue_bg, cap_spr, cap_bg;
    logic [CW-1:0]     bx_w, by_w, baddr, anim_c, saddr_sel;
    logic [NUM_SPR-1:0] hit;
    logic [CW-1:0]     saddr_spr [NUM_SPR];
    logic              hit_any;

    logic              hit_reg, von_reg;
    logic [CW-1:0]     saddr_reg, baddr_reg;
    logic [11:0]       spr_data_reg, nxt_reg;
    logic [ANIM_W-1:0] anim_reg;
    logic [DIV_W-1:0]  div_reg;

    logic              motion_en;

    assign bx_w      = CW'(pixel_x) >> SCALE_SH;
    assign by_w      = CW'(pixel_y) >> SCALE_SH;
    assign baddr     = by_w * VBUF_W_C + bx_w;
    assign anim_c    = CW'(anim_reg);
    assign motion_en = frame_tick && !pause;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPR; gi++) begin : g_spr
            localparam logic [CW-1:0] RY_C   = CW'(SPR_Y0 + gi * SPR_DY);
            localparam logic [CW-1:0] STEP_C = CW'(gi + 1);
            localparam logic [CW-1:0] BASE_C = CW'(gi * SPR_FRAMES);

            logic [POS_W-1:0] pos_reg;
            logic             dir_reg;   // 1 = moving left
            logic [CW-1:0]    pos_c, pos_next, col;
            logic             dir_next;

            assign pos_c   = CW'(pos_reg);
            // pos is the right edge, so the sprite covers bx in [pos-SPR_W, pos-1].
            assign hit[gi] = spr_en[gi] && (by_w >= RY_C) && (by_w < RY_C + SPR_H_C)
                             && (bx_w < pos_c) && (bx_w + SPR_W_C >= pos_c);
            assign col     = (BOUNCE != 0 && dir_reg) ? pos_c - ONE_C - bx_w
                                                      : bx_w + SPR_W_C - pos_c;
            assign saddr_spr[gi] = BG_SIZE_C
                                 + ((BASE_C + anim_c) * SPR_H_C + (by_w - RY_C)) * SPR_W_C + col;

            always_comb begin
                pos_next = pos_c;
                dir_next = dir_reg;
                if (BOUNCE == 0) begin
                    pos_next = (pos_c + STEP_C > MAX_POS_C) ? '0 : pos_c + STEP_C;
                end else if (!dir_reg) begin
                    if (pos_c + STEP_C >= VBUF_W_C) begin
                        pos_next = VBUF_W_C;
                        dir_next = 1'b1;
                    end else begin
                        pos_next = pos_c + STEP_C;
                    end
                end else begin
                    if (pos_c <= SPR_W_C + STEP_C) begin
                        pos_next = SPR_W_C;
                        dir_next = 1'b0;
                    end else begin
                        pos_next = pos_c - STEP_C;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    pos_reg <= POS_W'(gi * SPR_W);
                    dir_reg <= 1'b0;
                end else if (motion_en) begin
                    pos_reg <= pos_next[POS_W-1:0];
                    dir_reg <= dir_next;
                end
            end
        end
    endgenerate

    // Walk from lowest priority upward so the lowest-index hit wins.
    always_comb begin
        hit_any   = 1'b0;
        saddr_sel = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any   = 1'b1;
                saddr_sel = saddr_spr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            anim_reg <= '0;
            div_reg  <= '0;
        end else if (motion_en) begin
            if (div_reg == DIV_W'(ANIM_DIV - 1)) begin
                div_reg  <= '0;
                anim_reg <= (anim_reg == ANIM_W'(SPR_FRAMES - 1)) ? '0 : anim_reg + 1'b1;
            end else begin
                div_reg <= div_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_reg <= ST_IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (pixel_tick) state_next = ST_SPR;
            ST_SPR:  state_next = ST_BG;
            ST_BG:   state_next = ST_CAP1;
            ST_CAP1: state_next = ST_CAP2;
            ST_CAP2: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        latch_en  = (state_reg == ST_IDLE) && pixel_tick;
        issue_spr = (state_reg == ST_SPR);
        issue_bg  = (state_reg == ST_BG);
        cap_spr   = (state_reg == ST_CAP1);
        cap_bg    = (state_reg == ST_CAP2);
    end

    // Everything about the pixel is frozen in IDLE, so motion updates never disturb a fetch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rgb          <= '0;
            sram_addr    <= '0;
            overrun      <= 1'b0;
            hit_reg      <= 1'b0;
            von_reg      <= 1'b0;
            saddr_reg    <= '0;
            baddr_reg    <= '0;
            spr_data_reg <= '0;
            nxt_reg      <= '0;
        end else begin
            if (latch_en) begin
                rgb       <= nxt_reg;
                hit_reg   <= hit_any;
                von_reg   <= video_on;
                saddr_reg <= saddr_sel;
                baddr_reg <= baddr;
            end
            if (pixel_tick && state_reg != ST_IDLE) overrun <= 1'b1;
            if (issue_spr) sram_addr <= hit_reg ? saddr_reg[ADDR_W-1:0] : baddr_reg[ADDR_W-1:0];
            if (issue_bg)  sram_addr <= baddr_reg[ADDR_W-1:0];
            if (cap_spr)   spr_data_reg <= sram_data;
            if (cap_bg) begin
                if (!von_reg)                                 nxt_reg <= '0;
                else if (hit_reg && spr_data_reg != KEY_COLOR) nxt_reg <= spr_data_reg;
                else                                          nxt_reg <= sram_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: a wrap-mode instance (defaults) and a bounce-mode instance
// with overlapping sprite rows, both checked against a reference model and an rgb scoreboard.
module tb_sprite_compositor;
    logic        clk = 1'b0;
    logic        reset_n, pixel_tick, video_on, frame_tick, pause;
    logic [9:0]  pixel_x, pixel_y;
    logic [2:0]  en_a;
    logic [1:0]  en_b;
    logic [17:0] sram_addr_a, sram_addr_b;
    logic [11:0] sram_data_a, sram_data_b, rgb_a, rgb_b;
    logic        overrun_a, overrun_b;

    always #5 clk = ~clk;

    sprite_compositor dut_a (
        .clk(clk), .reset_n(reset_n), .pixel_tick(pixel_tick), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_tick(frame_tick), .pause(pause),
        .spr_en(en_a), .sram_addr(sram_addr_a), .sram_data(sram_data_a),
        .rgb(rgb_a), .overrun(overrun_a)
    );

    sprite_compositor #(.NUM_SPR(2), .SPR_DY(0), .BOUNCE(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .pixel_tick(pixel_tick), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_tick(frame_tick), .pause(pause),
        .spr_en(en_b), .sram_addr(sram_addr_b), .sram_data(sram_data_b),
        .rgb(rgb_b), .overrun(overrun_b)
    );

    // Image SRAM: sparse overrides on top of a deterministic non-key pattern.
    logic [11:0] mem [int];
    int          log_a[$], log_b[$];

    function automatic logic [11:0] mem_rd(input int a);
        logic [11:0] d;
        if (mem.exists(a)) return mem[a];
        d = 12'((a * 37 + 5) & 32'hFFF);
        if (d == 12'h0F0) d = 12'h0F1;
        return d;
    endfunction

    always @(posedge clk) begin
        sram_data_a <= mem_rd(int'(sram_addr_a));
        sram_data_b <= mem_rd(int'(sram_addr_b));
        log_a.push_back(int'(sram_addr_a));
        log_b.push_back(int'(sram_addr_b));
    end

    typedef struct {
        logic [11:0] ea;
        logic [11:0] eb;
    } exp_t;
    exp_t sb[$];
    exp_t p;

    int n_assert = 0;
    int n_fail   = 0;
    int pos_a[4], pos_b[4];
    bit dir_a[4], dir_b[4];
    int anim_m, div_m;
    int last_fb, s0, f1, b1;
    bit h1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_log(input int q[$], input int v);
        foreach (q[k]) if (q[k] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        pos_a = '{0, 64, 128, 0};
        pos_b = '{0, 64, 0, 0};
        dir_a = '{0, 0, 0, 0};
        dir_b = '{0, 0, 0, 0};
        anim_m = 0;
        div_m  = 0;
    endfunction

    function automatic void model_frame();
        if (pause) return;
        for (int i = 0; i < 3; i++) begin
            pos_a[i] += i + 1;
            if (pos_a[i] > 384) pos_a[i] = 0;
        end
        for (int i = 0; i < 2; i++) begin
            if (!dir_b[i]) begin
                if (pos_b[i] + i + 1 >= 320) begin pos_b[i] = 320; dir_b[i] = 1; end
                else pos_b[i] += i + 1;
            end else begin
                if (pos_b[i] <= 64 + i + 1) begin pos_b[i] = 64; dir_b[i] = 0; end
                else pos_b[i] -= i + 1;
            end
        end
        div_m++;
        if (div_m == 8) begin div_m = 0; anim_m = (anim_m + 1) % 2; end
    endfunction

    function automatic void model_pix(input bit bounce, input int nspr, input int dy,
                                      input logic [7:0] en, input int pos[4], input bit dir[4],
                                      input int x, input int y,
                                      output bit hit, output int fa, output int ba);
        int bx, by, ry, col;
        bx = x >> 1;
        by = y >> 1;
        ba = by * 320 + bx;
        fa = ba;
        hit = 1'b0;
        for (int i = nspr - 1; i >= 0; i--) begin
            ry = 64 + i * dy;
            if (en[i] && by >= ry && by < ry + 32 && bx < pos[i] && bx + 64 >= pos[i]) begin
                col = (bounce && dir[i]) ? pos[i] - 1 - bx : bx + 64 - pos[i];
                fa  = 76800 + ((i * 2 + anim_m) * 32 + by - ry) * 64 + col;
                hit = 1'b1;
            end
        end
    endfunction

    function automatic logic [11:0] exp_rgb(input bit von, input bit hit, input int fa, input int ba);
        logic [11:0] s;
        s = mem_rd(fa);
        if (!von) return 12'h000;
        if (hit && s != 12'h0F0) return s;
        return mem_rd(ba);
    endfunction

    task automatic frames(input int n);
        repeat (n) begin
            @(negedge clk); frame_tick = 1'b1;
            @(negedge clk); frame_tick = 1'b0;
            model_frame();
        end
    endtask

    // One pixel: expectation goes on the scoreboard, the previous pixel's rgb is checked.
    task automatic probe(input int x, input int y, input bit von, input bit ft, input string tag);
        bit   ha, hb;
        int   fa, ba, fb, bb;
        exp_t e, q;
        model_pix(1'b0, 3, 48, {5'd0, en_a}, pos_a, dir_a, x, y, ha, fa, ba);
        model_pix(1'b1, 2, 0, {6'd0, en_b}, pos_b, dir_b, x, y, hb, fb, bb);
        e.ea = exp_rgb(von, ha, fa, ba);
        e.eb = exp_rgb(von, hb, fb, bb);
        log_a.delete();
        log_b.delete();
        @(negedge clk);
        pixel_x = 10'(x); pixel_y = 10'(y); video_on = von;
        pixel_tick = 1'b1; frame_tick = ft;
        @(negedge clk);
        pixel_tick = 1'b0; frame_tick = 1'b0;
        if (ft) model_frame();
        if (sb.size() != 0) begin
            q = sb.pop_front();
            check({tag, "/rgb_a_prev"}, 32'(rgb_a), 32'(q.ea));
            check({tag, "/rgb_b_prev"}, 32'(rgb_b), 32'(q.eb));
        end
        sb.push_back(e);
        repeat (6) @(negedge clk);
        check({tag, "/addr_a_first"}, 32'(in_log(log_a, fa)), 1);
        check({tag, "/addr_a_bg"},    32'(in_log(log_a, ba)), 1);
        check({tag, "/addr_b_first"}, 32'(in_log(log_b, fb)), 1);
        check({tag, "/addr_b_bg"},    32'(in_log(log_b, bb)), 1);
        $display("pixel %s (%0d,%0d) von=%0b ft=%0b exp_a=%03h exp_b=%03h",
                 tag, x, y, von, ft, e.ea, e.eb);
        last_fb = fb;
    endtask

    initial begin
        reset_n = 1'b0; pixel_tick = 1'b0; video_on = 1'b0; frame_tick = 1'b0; pause = 1'b0;
        pixel_x = '0; pixel_y = '0; en_a = 3'b001; en_b = 2'b00;
        model_reset();
        mem[0]     = 12'h123;
        mem[22490] = 12'hABC;
        mem[77238] = 12'hF00;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst/rgb_a", 32'(rgb_a), 0);
        check("rst/addr_a", 32'(sram_addr_a), 0);
        check("rst/ovr_a", 32'(overrun_a), 0);
        check("rst/rgb_b", 32'(rgb_b), 0);

        probe(0, 0, 1'b1, 1'b0, "bg0");
        frames(85);
        en_a = 3'b100;
        probe(638, 320, 1'b1, 1'b0, "wrap_pre");
        probe(638, 320, 1'b1, 1'b1, "wrap_ft");
        probe(638, 320, 1'b1, 1'b0, "wrap_post");
        en_a = 3'b001;
        frames(14);
        probe(180, 140, 1'b1, 1'b0, "spr0");
        check("spr0/addr_77238", 32'(in_log(log_a, 77238)), 1);
        mem[77238] = 12'h0F0;
        probe(180, 140, 1'b1, 1'b0, "key");
        probe(180, 140, 1'b0, 1'b0, "blank");
        pause = 1'b1;
        frames(5);
        pause = 1'b0;
        probe(180, 140, 1'b1, 1'b0, "pause");
        check("pause/addr_77238", 32'(in_log(log_a, 77238)), 1);

        en_b = 2'b11;
        frames(92);
        model_pix(1'b1, 2, 0, 8'b10, pos_b, dir_b, 300, 140, h1, f1, b1);
        probe(300, 140, 1'b1, 1'b0, "prio_both");
        s0 = last_fb;
        check("prio_both/no_spr1", 32'(in_log(log_b, f1)), 0);
        en_b = 2'b10;
        probe(300, 140, 1'b1, 1'b0, "prio_en10");
        check("prio_en10/no_spr0", 32'(in_log(log_b, s0)), 0);
        check("prio_en10/spr1", 32'(in_log(log_b, f1)), 32'(h1));

        en_b = 2'b01;
        frames(127);
        probe(600, 140, 1'b1, 1'b0, "bounce_r");
        frames(1);
        probe(600, 140, 1'b1, 1'b0, "bounce_l");

        check("ovr/before", 32'(overrun_a), 0);
        @(negedge clk); pixel_tick = 1'b1;
        @(negedge clk); pixel_tick = 1'b0;
        p = sb.pop_front();
        check("ovr/rgb_a_prev", 32'(rgb_a), 32'(p.ea));
        check("ovr/rgb_b_prev", 32'(rgb_b), 32'(p.eb));
        @(negedge clk);
        @(negedge clk); pixel_tick = 1'b1;
        @(negedge clk); pixel_tick = 1'b0;
        check("ovr/set_a", 32'(overrun_a), 1);
        check("ovr/set_b", 32'(overrun_b), 1);
        repeat (10) @(negedge clk);
        check("ovr/sticky_a", 32'(overrun_a), 1);
        $display("overrun after 3-clk ticks: a=%0b b=%0b", overrun_a, overrun_b);

        @(negedge clk); pixel_tick = 1'b1;
        @(negedge clk); pixel_tick = 1'b0;
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        check("rst2/rgb_a", 32'(rgb_a), 0);
        check("rst2/ovr_a", 32'(overrun_a), 0);
        check("rst2/ovr_b", 32'(overrun_b), 0);
        check("rst2/addr_a", 32'(sram_addr_a), 0);
        $display("mid-pipeline reset: rgb_a=%03h overrun_a=%0b", rgb_a, overrun_a);
        sb.delete();
        model_reset();
        probe(0, 0, 1'b1, 1'b0, "post_rst0");
        probe(0, 0, 1'b1, 1'b0, "post_rst1");
        check("post_rst/ovr_a", 32'(overrun_a), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
